// File: rtl/udp_encap_mux_if.sv
// Handshake bundle of the UDP header inserter: descriptor in, payload in, datagram out.
// The slave view is the inserter itself; the master view is its surroundings.
interface udp_encap_mux_if #(
  parameter int DATA_W = 64,
  parameter int CH_W   = 2
);
  logic              desc_valid;
  logic              desc_ready;
  logic [CH_W-1:0]   desc_chan;
  logic [15:0]       desc_len;
  logic [DATA_W-1:0] s_tdata;
  logic              s_tvalid;
  logic              s_tready;
  logic              s_tlast;
  logic [DATA_W-1:0] m_tdata;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;

  modport master (
    output desc_valid, desc_chan, desc_len, s_tdata, s_tvalid, s_tlast, m_tready,
    input  desc_ready, s_tready, m_tdata, m_tvalid, m_tlast
  );

  modport slave (
    input  desc_valid, desc_chan, desc_len, s_tdata, s_tvalid, s_tlast, m_tready,
    output desc_ready, s_tready, m_tdata, m_tvalid, m_tlast
  );
endinterface

// File: rtl/udp_encap_mux.sv
// Multi-channel UDP header inserter: per descriptor, emits an 8-byte big-endian UDP
// header from the channel's port table, then forwards the payload through one output register.
//
//   state | meaning
//   IDLE  | waiting for a descriptor, output register empty
//   HDR   | header beats still to be loaded into the output register
//   PAY   | forwarding payload beats, counting down the expected beats
//   LAST  | final (tlast) beat sits in the output register, waiting to transfer
//   DROP  | discarding payload up to s_tlast; a pending tlast beat still drains
module udp_encap_mux #(
  parameter int DATA_W = 64,
  parameter int NUM_CH = 4,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH*16-1:0] cfg_sport,
  input  logic [NUM_CH*16-1:0] cfg_dport,
  udp_encap_mux_if.slave       bus,
  output logic                 err_len,
  output logic                 err_size,
  output logic [CNT_W-1:0]     pkt_cnt,
  output logic [CNT_W-1:0]     err_cnt
);
  localparam int          BYTES     = DATA_W / 8;
  localparam int          HDR_BEATS = 64 / DATA_W;
  localparam int          LG_BYTES  = $clog2(BYTES);
  localparam logic [15:0] MAX_LEN   = 16'd65527;

  typedef enum logic [2:0] {IDLE, HDR, PAY, LAST, DROP} state_t;

  state_t            state, state_nxt;
  logic [63:0]       hdr_q, hdr_d, hdr_new;
  logic [2:0]        hdr_left_q, hdr_left_d;
  logic [16:0]       beats_q, beats_d, exp_beats;
  logic              tail_q, tail_d;
  logic              m_tvalid_q, m_tvalid_d;
  logic              m_tlast_q, m_tlast_d;
  logic [DATA_W-1:0] m_tdata_q, m_tdata_d;
  logic              err_len_d, err_size_d;
  logic              desc_ready_c, s_tready_c;
  logic              chan_bad, desc_bad, out_free;
  logic [CH_W+3:0]   tbl_idx;

  // A power-of-two channel count cannot be addressed out of range.
  generate
    if (NUM_CH == (1 << CH_W)) begin : g_full
      assign chan_bad = 1'b0;
    end else begin : g_part
      assign chan_bad = (bus.desc_chan >= CH_W'(NUM_CH));
    end
  endgenerate

  assign tbl_idx   = {bus.desc_chan, 4'b0000};
  assign hdr_new   = {cfg_sport[tbl_idx +: 16], cfg_dport[tbl_idx +: 16],
                      bus.desc_len + 16'd8, 16'h0000};
  assign exp_beats = 17'(({1'b0, bus.desc_len} + 17'(BYTES - 1)) >> LG_BYTES);
  assign desc_bad  = (bus.desc_len > MAX_LEN) | chan_bad;
  assign out_free  = !m_tvalid_q | bus.m_tready;

  always_comb begin
    state_nxt    = state;
    desc_ready_c = 1'b0;
    s_tready_c   = 1'b0;
    m_tvalid_d   = m_tvalid_q & !bus.m_tready;
    m_tdata_d    = m_tdata_q;
    m_tlast_d    = m_tlast_q;
    hdr_d        = hdr_q;
    hdr_left_d   = hdr_left_q;
    beats_d      = beats_q;
    tail_d       = tail_q;
    err_len_d    = 1'b0;
    err_size_d   = 1'b0;
    case (state)
      IDLE: begin
        desc_ready_c = 1'b1;
        tail_d       = 1'b0;
        if (bus.desc_valid) begin
          if (desc_bad) begin
            err_size_d = 1'b1;
            state_nxt  = DROP;
          end else begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = hdr_new[63 -: DATA_W];
            m_tlast_d  = (HDR_BEATS == 1) && (exp_beats == 17'd0);
            hdr_d      = hdr_new << DATA_W;
            hdr_left_d = 3'(HDR_BEATS - 1);
            beats_d    = exp_beats;
            if (HDR_BEATS == 1) state_nxt = (exp_beats == 17'd0) ? LAST : PAY;
            else                state_nxt = HDR;
          end
        end
      end
      HDR: begin
        if (out_free) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = hdr_q[63 -: DATA_W];
          m_tlast_d  = (hdr_left_q == 3'd1) && (beats_q == 17'd0);
          hdr_d      = hdr_q << DATA_W;
          hdr_left_d = hdr_left_q - 3'd1;
          if (hdr_left_q == 3'd1) state_nxt = (beats_q == 17'd0) ? LAST : PAY;
        end
      end
      PAY: begin
        s_tready_c = out_free;
        if (out_free && bus.s_tvalid) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = bus.s_tdata;
          m_tlast_d  = 1'b0;
          beats_d    = beats_q - 17'd1;
          if (bus.s_tlast) begin
            m_tlast_d = 1'b1;
            err_len_d = (beats_q != 17'd1);
            state_nxt = LAST;
          end else if (beats_q == 17'd1) begin
            // Datagram closes at the declared length; the excess input is discarded.
            m_tlast_d = 1'b1;
            err_len_d = 1'b1;
            state_nxt = DROP;
          end
        end
      end
      LAST: begin
        if (bus.m_tready) state_nxt = IDLE;
      end
      DROP: begin
        s_tready_c = !tail_q;
        if (bus.s_tvalid && bus.s_tlast) tail_d = 1'b1;
        if ((tail_q || (bus.s_tvalid && bus.s_tlast)) && out_free) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hdr_q      <= '0;
      hdr_left_q <= '0;
      beats_q    <= '0;
      tail_q     <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
      err_len    <= 1'b0;
      err_size   <= 1'b0;
      pkt_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      hdr_q      <= hdr_d;
      hdr_left_q <= hdr_left_d;
      beats_q    <= beats_d;
      tail_q     <= tail_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tdata_q  <= m_tdata_d;
      err_len    <= err_len_d;
      err_size   <= err_size_d;
      if (m_tvalid_q && bus.m_tready && m_tlast_q) pkt_cnt <= pkt_cnt + CNT_W'(1);
      if (err_len_d || err_size_d) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign bus.desc_ready = desc_ready_c;
  assign bus.s_tready   = s_tready_c;
  assign bus.m_tvalid   = m_tvalid_q;
  assign bus.m_tlast    = m_tlast_q;
  assign bus.m_tdata    = m_tdata_q;
endmodule

// File: tb/tb_udp_encap_mux.sv
// Bench for udp_encap_mux: randomized packets against a datagram-level reference model,
// plus directed length/channel error, reset and narrow-bus cases.
module tb_udp_encap_mux;
  localparam int DW  = 64;
  localparam int NCH = 4;
  localparam int CHW = 2;
  localparam int CW  = 32;
  localparam int BY  = DW / 8;
  localparam int HB  = 64 / DW;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NCH*16-1:0] cfg_sport, cfg_dport;
  logic              err_len, err_size;
  logic [CW-1:0]     pkt_cnt, err_cnt;

  udp_encap_mux_if #(.DATA_W(DW), .CH_W(CHW)) bus ();
  udp_encap_mux #(.DATA_W(DW), .NUM_CH(NCH), .CH_W(CHW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .cfg_sport(cfg_sport), .cfg_dport(cfg_dport), .bus(bus),
    .err_len(err_len), .err_size(err_size), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
  );

  // Narrow 16-bit instance with a non-power-of-two channel count.
  logic [3*16-1:0] cfg16_sport, cfg16_dport;
  logic            err16_len, err16_size;
  logic [CW-1:0]   pkt16_cnt, err16_cnt;

  udp_encap_mux_if #(.DATA_W(16), .CH_W(2)) bus16 ();
  udp_encap_mux #(.DATA_W(16), .NUM_CH(3), .CH_W(2), .CNT_W(CW)) dut16 (
    .clk(clk), .rst(rst), .cfg_sport(cfg16_sport), .cfg_dport(cfg16_dport), .bus(bus16),
    .err_len(err16_len), .err_size(err16_size), .pkt_cnt(pkt16_cnt), .err_cnt(err16_cnt)
  );

  int            n_chk = 0;
  int            n_fail = 0;
  beat_t         exp_q[$];
  beat_t         log_q[$];
  logic [DW-1:0] pay_q[$];
  logic [16:0]   q16[$];
  logic [15:0]   t2_exp [4];
  int            bp_pct = 0;
  int            m_pkt = 0, m_err_len = 0, m_err_size = 0;
  int            got_err_len = 0, got_err_size = 0;
  bit            stall_v = 1'b0;
  bit            s16_seen = 1'b0;
  beat_t         stall_b, mb, eb;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    bus.m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.m_tready = ($urandom_range(99) >= bp_pct);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      stall_v = 1'b0;
    end else begin
      if (err_len) got_err_len++;
      if (err_size) got_err_size++;
      if (stall_v) begin
        check_val("stall_valid", bus.m_tvalid, 1'b1);
        check_val("stall_data", bus.m_tdata, stall_b.d);
        check_val("stall_last", bus.m_tlast, stall_b.l);
      end
      if (bus.m_tvalid && bus.m_tready) begin
        mb.d = bus.m_tdata;
        mb.l = bus.m_tlast;
        log_q.push_back(mb);
        check_val("beat_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          eb = exp_q.pop_front();
          check_val("beat_data", mb.d, eb.d);
          check_val("beat_last", mb.l, eb.l);
        end
      end
      stall_v   = bus.m_tvalid && !bus.m_tready;
      stall_b.d = bus.m_tdata;
      stall_b.l = bus.m_tlast;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus16.s_tready) s16_seen = 1'b1;
      if (bus16.m_tvalid && bus16.m_tready) q16.push_back({bus16.m_tlast, bus16.m_tdata});
    end
  end

  task automatic send_desc(input int ch, input int len);
    int t = 0;
    bus.desc_valid = 1'b1;
    bus.desc_chan  = CHW'(ch);
    bus.desc_len   = 16'(len);
    @(negedge clk);
    while (!bus.desc_ready && t < 300) begin
      t++;
      @(negedge clk);
    end
    check_val("desc_accept_in_time", t < 300, 1'b1);
    @(posedge clk);
    #1;
    bus.desc_valid = 1'b0;
  endtask

  task automatic send_beats();
    for (int i = 0; i < pay_q.size(); i++) begin
      int t = 0;
      if ($urandom_range(3) == 0) begin
        @(posedge clk);
        #1;
      end
      bus.s_tvalid = 1'b1;
      bus.s_tdata  = pay_q[i];
      bus.s_tlast  = (i == pay_q.size() - 1);
      @(negedge clk);
      while (!bus.s_tready && t < 300) begin
        t++;
        @(negedge clk);
      end
      check_val("beat_accept_in_time", t < 300, 1'b1);
      @(posedge clk);
      #1;
      bus.s_tvalid = 1'b0;
      bus.s_tlast  = 1'b0;
    end
  endtask

  // Reference: a datagram is the header words followed by the first min(n, E) payload beats.
  task automatic run_pkt(input int ch, input int len, input int n);
    logic [63:0] hdr;
    int          e;
    beat_t       b;
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back({$urandom, $urandom});
    e = (len + BY - 1) / BY;
    if (len > 65527 || ch >= NCH) begin
      m_err_size++;
    end else begin
      hdr = {cfg_sport[16*ch +: 16], cfg_dport[16*ch +: 16], 16'(len + 8), 16'h0000};
      for (int i = 0; i < HB; i++) begin
        b.d = hdr[63 - i*DW -: DW];
        b.l = (e == 0) && (i == HB - 1);
        exp_q.push_back(b);
      end
      for (int i = 0; i < n && i < e; i++) begin
        b.d = pay_q[i];
        b.l = (i == n - 1) || (i == e - 1);
        exp_q.push_back(b);
      end
      if (n != e) m_err_len++;
      m_pkt++;
    end
    send_desc(ch, len);
    if ($urandom_range(3) == 0) cfg_sport[16*ch +: 16] = 16'($urandom);
    send_beats();
  endtask

  task automatic drain_and_check();
    int t = 0;
    while (exp_q.size() > 0 && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_val("drain_in_time", t < 3000, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_val("pkt_cnt", pkt_cnt, m_pkt);
    check_val("err_cnt", err_cnt, m_err_len + m_err_size);
    check_val("err_len_pulses", got_err_len, m_err_len);
    check_val("err_size_pulses", got_err_size, m_err_size);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_desc_ready"}, bus.desc_ready, 1'b1);
    check_val({tag, "_s_tready"}, bus.s_tready, 1'b0);
    check_val({tag, "_m_tvalid"}, bus.m_tvalid, 1'b0);
    check_val({tag, "_m_tlast"}, bus.m_tlast, 1'b0);
    check_val({tag, "_m_tdata"}, bus.m_tdata, '0);
    check_val({tag, "_err_len"}, err_len, 1'b0);
    check_val({tag, "_err_size"}, err_size, 1'b0);
    check_val({tag, "_pkt_cnt"}, pkt_cnt, '0);
    check_val({tag, "_err_cnt"}, err_cnt, '0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int ch, len, e, n;
    bus.desc_valid = 1'b0; bus.desc_chan = '0; bus.desc_len = '0;
    bus.s_tvalid = 1'b0; bus.s_tdata = '0; bus.s_tlast = 1'b0;
    bus16.desc_valid = 1'b0; bus16.desc_chan = '0; bus16.desc_len = '0;
    bus16.s_tvalid = 1'b0; bus16.s_tdata = '0; bus16.s_tlast = 1'b0; bus16.m_tready = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      cfg_sport[16*i +: 16] = 16'(16'h1000 + i);
      cfg_dport[16*i +: 16] = 16'(16'h2000 + i);
    end
    cfg_sport[16 +: 16] = 16'h1234;
    cfg_dport[16 +: 16] = 16'h0009;
    cfg16_sport = {16'h3333, 16'h2222, 16'h1234};
    cfg16_dport = {16'h0c0c, 16'h0b0b, 16'h0009};
    t2_exp[0] = 16'h1234; t2_exp[1] = 16'h0009; t2_exp[2] = 16'h0008; t2_exp[3] = 16'h0000;

    @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // T1: 16-byte payload on channel 1
    log_q.delete();
    run_pkt(1, 16, 2);
    drain_and_check();
    check_val("t1_beats", log_q.size(), 3);
    if (log_q.size() == 3) begin
      check_val("t1_hdr", log_q[0].d, 64'h1234_0009_0018_0000);
      check_val("t1_tlast", {log_q[0].l, log_q[1].l, log_q[2].l}, 3'b001);
    end
    check_val("t1_pkt_cnt", pkt_cnt, 1);

    // T4: early s_tlast, then a clean packet
    run_pkt(2, 24, 2);
    drain_and_check();
    check_val("t4_err_cnt", err_cnt, 1);
    run_pkt(3, 8, 1);
    drain_and_check();

    // T5: overlong input, oversize length, boundary lengths
    run_pkt(0, 8, 3);
    drain_and_check();
    run_pkt(1, 65528, 2);
    drain_and_check();
    check_val("t5_err_cnt", err_cnt, 3);
    run_pkt(2, 65527, 1);
    run_pkt(0, 0, 0);
    run_pkt(3, 1, 1);
    run_pkt(3, 9, 2);
    drain_and_check();

    // T3: random traffic under 50% backpressure
    bp_pct = 50;
    repeat (100) begin
      ch = $urandom_range(NCH - 1);
      if ($urandom_range(9) == 0) len = 65528 + $urandom_range(7);
      else                        len = $urandom_range(80);
      e = (len + BY - 1) / BY;
      if (len > 65527)  n = 1 + $urandom_range(2);
      else if (e == 0)  n = 0;
      else begin
        case ($urandom_range(7))
          0:       n = (e > 1) ? e - 1 : e + 1;
          1:       n = e + 1 + $urandom_range(1);
          default: n = e;
        endcase
      end
      run_pkt(ch, len, n);
    end
    drain_and_check();
    bp_pct = 0;

    // T6: reset while a packet is in its payload phase
    mb.d = {cfg_sport[32 +: 16], cfg_dport[32 +: 16], 16'd40, 16'h0000};
    mb.l = 1'b0;
    exp_q.push_back(mb);
    mb.d = 64'h0123_4567_89ab_cdef;
    exp_q.push_back(mb);
    send_desc(2, 32);
    bus.s_tvalid = 1'b1; bus.s_tdata = 64'h0123_4567_89ab_cdef; bus.s_tlast = 1'b0;
    t = 0;
    @(negedge clk);
    while (!bus.s_tready && t < 300) begin
      t++;
      @(negedge clk);
    end
    check_val("t6_beat_in_time", t < 300, 1'b1);
    @(posedge clk);
    #1;
    bus.s_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("t6_pending", exp_q.size(), 0);
    check_val("t6_in_payload", bus.s_tready, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t6");
    rst = 1'b0;
    exp_q.delete();
    m_pkt = 0; m_err_len = 0; m_err_size = 0;
    got_err_len = 0; got_err_size = 0;
    @(posedge clk);
    #1;
    run_pkt(1, 20, 3);
    drain_and_check();
    check_val("t6_pkt_cnt_after", pkt_cnt, 1);

    // T2: 16-bit bus, zero-length payload -> header only
    q16.delete();
    s16_seen = 1'b0;
    bus16.desc_valid = 1'b1; bus16.desc_chan = 2'd0; bus16.desc_len = 16'd0;
    t = 0;
    @(negedge clk);
    while (!bus16.desc_ready && t < 300) begin
      t++;
      @(negedge clk);
    end
    check_val("t2_desc_in_time", t < 300, 1'b1);
    @(posedge clk);
    #1;
    bus16.desc_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_val("t2_beats", q16.size(), 4);
    if (q16.size() == 4) begin
      for (int i = 0; i < 4; i++) check_val("t2_beat", q16[i], {(i == 3), t2_exp[i]});
    end
    check_val("t2_no_s_tready", s16_seen, 1'b0);
    check_val("t2_pkt_cnt", pkt16_cnt, 1);

    // Channel index beyond the table -> err_size and dropped payload
    bus16.desc_valid = 1'b1; bus16.desc_chan = 2'd3; bus16.desc_len = 16'd4;
    t = 0;
    @(negedge clk);
    while (!bus16.desc_ready && t < 300) begin
      t++;
      @(negedge clk);
    end
    check_val("t2_bad_desc_in_time", t < 300, 1'b1);
    @(posedge clk);
    #1;
    bus16.desc_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus16.s_tvalid = 1'b1; bus16.s_tdata = 16'(16'hab00 + i); bus16.s_tlast = (i == 1);
      t = 0;
      @(negedge clk);
      while (!bus16.s_tready && t < 300) begin
        t++;
        @(negedge clk);
      end
      check_val("t2_drop_in_time", t < 300, 1'b1);
      @(posedge clk);
      #1;
      bus16.s_tvalid = 1'b0; bus16.s_tlast = 1'b0;
    end
    repeat (5) @(posedge clk);
    #1;
    check_val("t2_err_cnt", err16_cnt, 1);
    check_val("t2_no_output", q16.size(), 4);
    check_val("t2_pkt_cnt_hold", pkt16_cnt, 1);
    check_val("t2_desc_ready_back", bus16.desc_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
